// File: rtl/aes_job_scheduler.sv
// rtl/aes_job_scheduler.sv - job sequencer and round-robin arbiter for a shared iterative AES round datapath
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   all_keys          expanded key schedule, round key i at [i*DATA_W +: DATA_W]
//   req0_*, req1_*    job request ports (valid/ready, mode 0=enc 1=dec, data block)
//   dp_load, dp_step  datapath control: load (data_in ^ key) or one round step
//   dp_mode/round     mode and round index of the job in flight
//   dp_round_key      round key selected for the current cycle
//   dp_data_in        captured input block
//   dp_state          datapath state register (result source)
//   resp_*            result port (valid/ready, data, owning requester id)
//   busy              high whenever not IDLE
//   jobs_done         completed response handshakes, wrapping 16-bit count
module aes_job_scheduler #(
  parameter int NR     = 10,
  parameter int DATA_W = 128
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [(NR+1)*DATA_W-1:0]   all_keys,
  input  logic                       req0_valid,
  output logic                       req0_ready,
  input  logic                       req0_mode,
  input  logic [DATA_W-1:0]          req0_data,
  input  logic                       req1_valid,
  output logic                       req1_ready,
  input  logic                       req1_mode,
  input  logic [DATA_W-1:0]          req1_data,
  output logic                       dp_load,
  output logic                       dp_step,
  output logic                       dp_mode,
  output logic [3:0]                 dp_round,
  output logic [DATA_W-1:0]          dp_round_key,
  output logic [DATA_W-1:0]          dp_data_in,
  input  logic [DATA_W-1:0]          dp_state,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [DATA_W-1:0]          resp_data,
  output logic                       resp_id,
  output logic                       busy,
  output logic [15:0]                jobs_done
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ROUND, S_RESP} state_e;

  localparam logic [3:0] NR_L = 4'(NR);

  state_e              state_q, state_d;
  logic                rr_q, rr_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                mode_q, mode_d;
  logic                id_q, id_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   resp_data_q, resp_data_d;
  logic                resp_held_q, resp_held_d;
  logic [15:0]         jobs_q, jobs_d;

  logic                grant;
  logic [3:0]          key_idx;

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    cnt_d        = cnt_q;
    mode_d       = mode_q;
    id_d         = id_q;
    data_d       = data_q;
    resp_data_d  = resp_data_q;
    resp_held_d  = resp_held_q;
    jobs_d       = jobs_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    dp_load      = 1'b0;
    dp_step      = 1'b0;
    dp_round     = 4'd0;
    key_idx      = 4'd0;
    resp_valid   = 1'b0;

    // On a tie the requester that did not win last time is chosen.
    if (req0_valid && req1_valid) begin
      grant = ~rr_q;
    end else begin
      grant = req1_valid;
    end

    case (state_q)
      S_IDLE: begin
        req0_ready = req0_valid & ~grant;
        req1_ready = req1_valid & grant;
        if (req0_ready || req1_ready) begin
          data_d  = grant ? req1_data : req0_data;
          mode_d  = grant ? req1_mode : req0_mode;
          id_d    = grant;
          rr_d    = grant;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        dp_load = 1'b1;
        key_idx = mode_q ? NR_L : 4'd0;
        cnt_d   = 4'd1;
        state_d = S_ROUND;
      end
      S_ROUND: begin
        dp_step  = 1'b1;
        dp_round = cnt_q;
        key_idx  = mode_q ? (NR_L - cnt_q) : cnt_q;
        if (cnt_q == NR_L) begin
          resp_held_d = 1'b0;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        // dp_state only holds the final block on the first RESP cycle;
        // snapshot it there so the response stays stable under backpressure.
        if (!resp_held_q) begin
          resp_data_d = dp_state;
          resp_held_d = 1'b1;
        end
        if (resp_ready) begin
          jobs_d      = jobs_q + 16'd1;
          resp_held_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dp_round_key = '0;
    for (int i = 0; i <= NR; i++) begin
      if (key_idx == 4'(i)) begin
        dp_round_key = all_keys[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_q        <= 1'b1;
      cnt_q       <= 4'd0;
      mode_q      <= 1'b0;
      id_q        <= 1'b0;
      data_q      <= '0;
      resp_data_q <= '0;
      resp_held_q <= 1'b0;
      jobs_q      <= 16'd0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      id_q        <= id_d;
      data_q      <= data_d;
      resp_data_q <= resp_data_d;
      resp_held_q <= resp_held_d;
      jobs_q      <= jobs_d;
    end
  end

  assign resp_data  = (state_q == S_RESP && !resp_held_q) ? dp_state : resp_data_q;
  assign resp_id    = id_q;
  assign dp_mode    = mode_q;
  assign dp_data_in = data_q;
  assign busy       = (state_q != S_IDLE);
  assign jobs_done  = jobs_q;

endmodule

// File: tb/tb_aes_job_scheduler.sv
// tb/tb_aes_job_scheduler.sv - scoreboard bench for aes_job_scheduler with a behavioural AES round datapath
module tb_aes_job_scheduler;

  localparam int NR = 10;
  localparam int DW = 128;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [(NR+1)*DW-1:0]   all_keys;
  logic                   req0_valid, req0_ready, req0_mode;
  logic [DW-1:0]          req0_data;
  logic                   req1_valid, req1_ready, req1_mode;
  logic [DW-1:0]          req1_data;
  logic                   dp_load, dp_step, dp_mode;
  logic [3:0]             dp_round;
  logic [DW-1:0]          dp_round_key, dp_data_in, dp_state;
  logic                   resp_valid, resp_ready, resp_id, busy;
  logic [DW-1:0]          resp_data;
  logic [15:0]            jobs_done;

  aes_job_scheduler #(.NR(NR), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .all_keys(all_keys),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_mode(req0_mode), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_mode(req1_mode), .req1_data(req1_data),
    .dp_load(dp_load), .dp_step(dp_step), .dp_mode(dp_mode), .dp_round(dp_round),
    .dp_round_key(dp_round_key), .dp_data_in(dp_data_in), .dp_state(dp_state),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_id(resp_id),
    .busy(busy), .jobs_done(jobs_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_resp = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- AES reference ----------------
  logic [7:0]   sbox_t [256];
  logic [7:0]   isbox_t[256];
  logic [127:0] rk[NR+1];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, x;
    r = 8'h00; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = xt(x);
    end
    return r;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] gb(input logic [127:0] s, input int i);
    return s[127-8*i -: 8];
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s, input bit inv);
    logic [7:0] m[4];
    logic [7:0] col[4];
    logic [7:0] v;
    logic [127:0] o;
    if (inv) begin m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09; end
    else     begin m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01; end
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) col[j] = gb(s, 4*c+j);
      for (int r = 0; r < 4; r++) begin
        v = 8'h00;
        for (int j = 0; j < 4; j++) v = v ^ gm(m[(j-r+4)%4], col[j]);
        o[127-8*(4*c+r) -: 8] = v;
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] k, input bit last);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = sbox_t[gb(s, 4*((c+r)%4)+r)];
    if (!last) o = mix(o, 1'b0);
    return o ^ k;
  endfunction

  function automatic logic [127:0] dec_round(input logic [127:0] s, input logic [127:0] k, input bit last);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = isbox_t[gb(s, 4*((c-r+4)%4)+r)];
    o = o ^ k;
    if (!last) o = mix(o, 1'b1);
    return o;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rk[0];
    for (int r = 1; r <= NR; r++) s = enc_round(s, rk[r], r == NR);
    return s;
  endfunction

  function automatic logic [127:0] aes_dec(input logic [127:0] ct);
    logic [127:0] s;
    s = ct ^ rk[NR];
    for (int c = 1; c <= NR; c++) s = dec_round(s, rk[NR-c], c == NR);
    return s;
  endfunction

  task automatic build_tables_and_keys();
    logic [7:0]  inv, s;
    logic [31:0] w[4*(NR+1)];
    logic [31:0] t;
    logic [7:0]  rcon;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
      sbox_t[x]  = s;
      isbox_t[s] = 8'(x);
    end
    w[0] = 32'h00010203; w[1] = 32'h04050607; w[2] = 32'h08090a0b; w[3] = 32'h0c0d0e0f;
    rcon = 8'h01;
    for (int i = 4; i < 4*(NR+1); i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t = t ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int j = 0; j <= NR; j++) begin
      rk[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
      all_keys[j*DW +: DW] = rk[j];
    end
  endtask

  // ---------------- behavioural round datapath ----------------
  logic [127:0] dp_st = '0;
  always @(posedge clk) begin
    if (dp_load)      dp_st <= dp_data_in ^ dp_round_key;
    else if (dp_step) dp_st <= dp_mode ? dec_round(dp_st, dp_round_key, dp_round == 4'(NR))
                                       : enc_round(dp_st, dp_round_key, dp_round == 4'(NR));
  end
  assign dp_state = dp_st;

  // ---------------- scoreboard / monitor ----------------
  typedef struct packed {
    logic         id;
    logic [127:0] data;
  } exp_t;

  exp_t         sb[$];
  logic         gq[$];
  int           acc_cyc = 0;
  logic         acc_mode = 1'b0;
  logic [127:0] acc_data = '0;
  int           exp_round = 0;
  bit           hold_prev = 0, hs_prev = 0, prev_rv = 0;
  logic [127:0] hold_data = '0, last_data = '0;
  logic         hold_id = 1'b0, last_id = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      sb.delete();
      hold_prev = 0; hs_prev = 0; prev_rv = 0; exp_round = 0;
    end
  end

  task automatic note_accept(input logic id, input logic mode, input logic [127:0] d);
    exp_t e;
    e.id   = id;
    e.data = mode ? aes_dec(d) : aes_enc(d);
    sb.push_back(e);
    gq.push_back(id);
    acc_cyc  = cyc;
    acc_mode = mode;
    acc_data = d;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      chk("one_ready", {127'b0, req0_ready & req1_ready}, 128'd0);
      if (req0_valid && req0_ready) note_accept(1'b0, req0_mode, req0_data);
      if (req1_valid && req1_ready) note_accept(1'b1, req1_mode, req1_data);
      if (dp_load) begin
        chk("load_round", dp_round, 0);
        chk("load_key", dp_round_key, acc_mode ? rk[NR] : rk[0]);
        chk("load_data", dp_data_in, acc_data);
        chk("load_mode", dp_mode, acc_mode);
        exp_round = 1;
      end
      if (dp_step) begin
        chk("step_round", dp_round, exp_round);
        chk("step_key", dp_round_key, acc_mode ? rk[NR-exp_round] : rk[exp_round]);
        exp_round++;
      end
      if (hold_prev) begin
        chk("bp_valid", resp_valid, 1);
        chk("bp_data", resp_data, hold_data);
        chk("bp_id", resp_id, hold_id);
      end
      if (hs_prev) chk("valid_drop", resp_valid, 0);
      if (resp_valid && !prev_rv) begin
        chk("latency", cyc - acc_cyc, NR + 2);
        chk("n_steps", exp_round, NR + 1);
      end
      if (resp_valid && resp_ready) begin
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          e = sb.pop_front();
          chk("resp_data", resp_data, e.data);
          chk("resp_id", resp_id, e.id);
        end
        last_data = resp_data;
        last_id   = resp_id;
        n_resp++;
      end
      hold_prev = resp_valid & ~resp_ready;
      hs_prev   = resp_valid & resp_ready;
      hold_data = resp_data;
      hold_id   = resp_id;
      prev_rv   = resp_valid;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_resp(input int start);
    bit ok;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(posedge clk); #2;
      if (n_resp > start) ok = 1;
    end
    if (!ok) chk("resp_timeout", 0, 1);
  endtask

  task automatic start_job(input logic id, input logic mode, input logic [127:0] d);
    bit ok;
    @(posedge clk); #1;
    if (id == 1'b0) begin req0_valid = 1'b1; req0_mode = mode; req0_data = d; end
    else            begin req1_valid = 1'b1; req1_mode = mode; req1_data = d; end
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if ((id == 1'b0 && req0_ready) || (id == 1'b1 && req1_ready)) ok = 1;
    end
    @(posedge clk); #1;
    if (id == 1'b0) req0_valid = 1'b0; else req1_valid = 1'b0;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic run_job(input logic id, input logic mode, input logic [127:0] d);
    int start;
    start = n_resp;
    start_job(id, mode, d);
    wait_resp(start);
  endtask

  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  initial begin
    int  start;
    bit  ok;
    rst = 1'b1;
    req0_valid = 1'b0; req0_mode = 1'b0; req0_data = '0;
    req1_valid = 1'b0; req1_mode = 1'b0; req1_data = '0;
    resp_ready = 1'b1;
    all_keys   = '0;
    build_tables_and_keys();

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_id", resp_id, 0);
    chk("rst_jobs", jobs_done, 0);
    chk("rst_load", dp_load, 0);
    chk("rst_step", dp_step, 0);
    chk("rst_round", dp_round, 0);
    chk("rst_mode", dp_mode, 0);
    chk("rst_data_in", dp_data_in, 0);
    chk("rst_ready", {req0_ready, req1_ready}, 0);
    @(posedge clk); #1 rst = 1'b0;

    // FIPS-197 C.1 encrypt then decrypt
    run_job(1'b0, 1'b0, PT);
    chk("enc_data", last_data, CT);
    chk("enc_id", last_id, 0);
    chk("enc_jobs", jobs_done, 1);
    run_job(1'b1, 1'b1, CT);
    chk("dec_data", last_data, PT);
    chk("dec_id", last_id, 1);
    chk("dec_jobs", jobs_done, 2);

    // random jobs, both modes and requesters
    for (int i = 0; i < 4; i++)
      run_job(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              {$urandom, $urandom, $urandom, $urandom});

    // arbitration after reset with both requesters always valid
    apply_reset();
    gq.delete();
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_mode = 1'b0; req0_data = {4{$urandom}};
    req1_valid = 1'b1; req1_mode = 1'b1; req1_data = {4{$urandom}};
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge clk); #1;
      if (gq.size() >= 4) ok = 1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    if (!ok) chk("arb_timeout", 0, 1);
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(posedge clk); #2;
      if (sb.size() == 0 && !busy) ok = 1;
    end
    if (!ok) chk("arb_drain_timeout", 0, 1);
    if (gq.size() >= 4) begin
      chk("arb_g0", gq[0], 0);
      chk("arb_g1", gq[1], 1);
      chk("arb_g2", gq[2], 0);
      chk("arb_g3", gq[3], 1);
    end

    // backpressure with a pending request on the other port
    resp_ready = 1'b0;
    start = n_resp;
    start_job(1'b0, 1'b0, PT);
    req1_valid = 1'b1; req1_mode = 1'b0; req1_data = CT;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (resp_valid) ok = 1;
    end
    if (!ok) chk("bp_resp_timeout", 0, 1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_no_accept", req1_ready, 0);
    end
    @(posedge clk); #1 resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_no_accept", req1_ready, 0);
    chk("bp_hs_data", resp_data, CT);
    @(negedge clk);
    chk("bp_accept_resumes", req1_ready, 1);
    @(posedge clk); #1 req1_valid = 1'b0;
    wait_resp(start + 1);

    // reset in the middle of ROUND at counter 5
    start_job(1'b0, 1'b0, {4{$urandom}});
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (dp_step && dp_round == 4'd5) ok = 1;
    end
    if (!ok) chk("mid_round_timeout", 0, 1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_busy", busy, 0);
    chk("mid_resp_valid", resp_valid, 0);
    chk("mid_jobs", jobs_done, 0);
    run_job(1'b1, 1'b1, CT);
    chk("mid_after_data", last_data, PT);
    chk("mid_after_jobs", jobs_done, 1);

    // jobs_done wrap
    @(negedge clk);
    force dut.jobs_q = 16'hffff;
    @(negedge clk);
    chk("wrap_preload", jobs_done, 16'hffff);
    release dut.jobs_q;
    run_job(1'b0, 1'b0, PT);
    chk("wrap_jobs", jobs_done, 16'h0000);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
